// File: rtl/v_table_init_ctrl.sv
// Write-port controller for BANKS replicated state SRAMs.
// Sequences full-table init and bank-masked range clears, arbitrated against update-pipeline writes.
module v_table_init_ctrl #(
  parameter int unsigned  N         = 256,
  parameter int unsigned  W         = 64,
  parameter int unsigned  BANKS     = 2,
  parameter logic [W-1:0] INIT_VAL  = '0,
  parameter bit           AUTO_INIT = 1'b1,
  localparam int unsigned AW        = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_init,
  input  logic             i_clr_vld,
  output logic             o_clr_rdy,
  input  logic [AW-1:0]    i_clr_base,
  input  logic [AW:0]      i_clr_len,
  input  logic [BANKS-1:0] i_clr_bank_mask,
  input  logic             i_pipe_wen,
  input  logic [AW-1:0]    i_pipe_waddr,
  input  logic [W-1:0]     i_pipe_wdata,
  output logic [BANKS-1:0] o_wen_r,
  output logic [AW-1:0]    o_waddr_r,
  output logic [W-1:0]     o_wdata_r,
  output logic             o_busy_r,
  output logic             o_done_r,
  output logic             o_drop_r
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FULL  = 2'd1,
    S_RANGE = 2'd2
  } state_t;

  localparam logic [AW-1:0]    LAST_IDX  = AW'(N - 1);
  localparam logic [AW:0]      N_LEN     = (AW + 1)'(N);
  localparam logic [BANKS-1:0] ALL_BANKS = '1;

  state_t           r_state;
  logic [AW-1:0]    r_ptr;
  logic [AW:0]      r_rem;
  logic [BANKS-1:0] r_mask;
  logic             r_fin;

  state_t           w_state;
  logic [AW-1:0]    w_ptr;
  logic [AW:0]      w_rem;
  logic [BANKS-1:0] w_mask;
  logic             w_fin;
  logic [BANKS-1:0] w_wen;
  logic [AW-1:0]    w_waddr;
  logic [W-1:0]     w_wdata;
  logic             w_busy;
  logic             w_done;
  logic             w_drop;
  logic             w_clr_rdy;

  logic [AW-1:0]    w_ptr_inc;
  logic [AW:0]      w_clr_len_sat;

  // Pointer advance wraps at the table end, which need not be a power of two.
  assign w_ptr_inc     = (r_ptr == LAST_IDX) ? '0 : r_ptr + AW'(1);
  assign w_clr_len_sat = (i_clr_len > N_LEN) ? N_LEN : i_clr_len;
  assign o_clr_rdy     = w_clr_rdy;

  // Next-state, write-port selection and status.
  always_comb begin
    w_state   = r_state;
    w_ptr     = r_ptr;
    w_rem     = r_rem;
    w_mask    = r_mask;
    w_fin     = 1'b0;
    w_wen     = '0;
    w_waddr   = o_waddr_r;
    w_wdata   = o_wdata_r;
    w_busy    = (r_state == S_FULL);
    w_done    = r_fin;
    w_drop    = o_drop_r;
    w_clr_rdy = 1'b0;

    case (r_state)
      S_FULL: begin
        w_wen   = ALL_BANKS;
        w_waddr = r_ptr;
        w_wdata = INIT_VAL;
        if (i_pipe_wen) begin
          w_drop = 1'b1;
        end
        if (i_init) begin
          w_ptr = '0;
        end else if (r_ptr == LAST_IDX) begin
          w_state = S_IDLE;
          w_ptr   = '0;
          w_fin   = 1'b1;
        end else begin
          w_ptr = w_ptr_inc;
        end
      end

      S_IDLE: begin
        if (i_pipe_wen) begin
          w_wen   = ALL_BANKS;
          w_waddr = i_pipe_waddr;
          w_wdata = i_pipe_wdata;
        end
        if (i_init) begin
          w_state = S_FULL;
          w_ptr   = '0;
        end else begin
          w_clr_rdy = 1'b1;
          if (i_clr_vld) begin
            if (i_clr_len == '0) begin
              w_done = 1'b1;
            end else begin
              w_state = S_RANGE;
              w_ptr   = i_clr_base;
              w_rem   = w_clr_len_sat;
              w_mask  = i_clr_bank_mask;
            end
          end
        end
      end

      S_RANGE: begin
        // Pipeline writes win the port; the clear simply stalls for that cycle.
        if (i_pipe_wen) begin
          w_wen   = ALL_BANKS;
          w_waddr = i_pipe_waddr;
          w_wdata = i_pipe_wdata;
        end
        if (i_init) begin
          w_state = S_FULL;
          w_ptr   = '0;
          w_rem   = '0;
        end else if (!i_pipe_wen) begin
          w_wen   = r_mask;
          w_waddr = r_ptr;
          w_wdata = INIT_VAL;
          w_ptr   = w_ptr_inc;
          w_rem   = r_rem - (AW + 1)'(1);
          if (r_rem == (AW + 1)'(1)) begin
            w_state = S_IDLE;
            w_fin   = 1'b1;
          end
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= AUTO_INIT ? S_FULL : S_IDLE;
      r_ptr     <= '0;
      r_rem     <= '0;
      r_mask    <= '0;
      r_fin     <= 1'b0;
      o_wen_r   <= '0;
      o_waddr_r <= '0;
      o_wdata_r <= '0;
      o_busy_r  <= AUTO_INIT;
      o_done_r  <= 1'b0;
      o_drop_r  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_ptr     <= w_ptr;
      r_rem     <= w_rem;
      r_mask    <= w_mask;
      r_fin     <= w_fin;
      o_wen_r   <= w_wen;
      o_waddr_r <= w_waddr;
      o_wdata_r <= w_wdata;
      o_busy_r  <= w_busy;
      o_done_r  <= w_done;
      o_drop_r  <= w_drop;
    end
  end

endmodule

// File: tb/tb_v_table_init_ctrl.sv
// Bench for v_table_init_ctrl: directed scenarios plus randomized ops against a shadow-memory model.
module tb_v_table_init_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned W  = 16;
  localparam int unsigned AW = 3;
  localparam logic [W-1:0] IV = 16'hA5A5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_init = 1'b0;
  logic          i_clr_vld = 1'b0;
  logic          o_clr_rdy;
  logic [AW-1:0] i_clr_base = '0;
  logic [AW:0]   i_clr_len = '0;
  logic [1:0]    i_clr_bank_mask = '0;
  logic          i_pipe_wen = 1'b0;
  logic [AW-1:0] i_pipe_waddr = '0;
  logic [W-1:0]  i_pipe_wdata = '0;
  logic [1:0]    o_wen_r;
  logic [AW-1:0] o_waddr_r;
  logic [W-1:0]  o_wdata_r;
  logic          o_busy_r;
  logic          o_done_r;
  logic          o_drop_r;

  v_table_init_ctrl #(
    .N(8), .W(16), .BANKS(2), .INIT_VAL(16'hA5A5), .AUTO_INIT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .i_init(i_init),
    .i_clr_vld(i_clr_vld), .o_clr_rdy(o_clr_rdy), .i_clr_base(i_clr_base),
    .i_clr_len(i_clr_len), .i_clr_bank_mask(i_clr_bank_mask),
    .i_pipe_wen(i_pipe_wen), .i_pipe_waddr(i_pipe_waddr), .i_pipe_wdata(i_pipe_wdata),
    .o_wen_r(o_wen_r), .o_waddr_r(o_waddr_r), .o_wdata_r(o_wdata_r),
    .o_busy_r(o_busy_r), .o_done_r(o_done_r), .o_drop_r(o_drop_r)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int rdylo_cnt = 0;
  int         q_addr[$];
  logic [1:0] q_wen[$];
  logic [W-1:0] q_data[$];
  int         q_cyc[$];
  logic [W-1:0] sh [2][8];
  logic [W-1:0] m  [2][8];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: sample outputs after the edge and record writes into the shadow SRAMs.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (o_wen_r != 2'b00) begin
      q_addr.push_back(int'(o_waddr_r));
      q_wen.push_back(o_wen_r);
      q_data.push_back(o_wdata_r);
      q_cyc.push_back(cyc);
      for (int b = 0; b < 2; b++)
        if (o_wen_r[b]) sh[b][o_waddr_r] = o_wdata_r;
    end
    if (o_busy_r) busy_cnt++;
    if (o_done_r) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!o_clr_rdy) rdylo_cnt++;
  endtask

  task automatic clear_log();
    q_addr.delete(); q_wen.delete(); q_data.delete(); q_cyc.delete();
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; rdylo_cnt = 0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int start;
    int k;
    start = done_cnt;
    k = 0;
    while (done_cnt == start && k < max_cyc) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != start), 1);
  endtask

  task automatic check_done_lat(input string tag);
    if (q_cyc.size() > 0)
      chk({tag, "_done_lat"}, done_cyc, q_cyc[q_cyc.size()-1] + 1);
  endtask

  // Expect eight all-bank INIT writes to 0..N-1 starting at log index from.
  task automatic check_full(input string tag, input int from);
    chk({tag, "_nwr"}, q_addr.size() - from, 8);
    if (q_addr.size() >= from + 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("%s_addr%0d", tag, i), q_addr[from+i], i);
        chk($sformatf("%s_wen%0d", tag, i), q_wen[from+i], 2'b11);
        chk($sformatf("%s_data%0d", tag, i), q_data[from+i], IV);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beef;
    int found;
    int k;
    int ea [4];
    logic [W-1:0] ed [4];

    // Reset state, before any clock edge is seen with reset released.
    #12;
    chk("rst_wen", o_wen_r, 0);
    chk("rst_addr", o_waddr_r, 0);
    chk("rst_data", o_wdata_r, 0);
    chk("rst_busy", o_busy_r, 1);
    chk("rst_done", o_done_r, 0);
    chk("rst_drop", o_drop_r, 0);
    chk("rst_rdy", o_clr_rdy, 0);
    #6 rst = 1'b1;
    clear_log();

    // Auto init after reset release.
    wait_done("auto", 20);
    check_full("auto", 0);
    chk("auto_busy_cnt", busy_cnt, 8);
    check_done_lat("auto");
    tick();
    chk("auto_done_once", done_cnt, 1);
    chk("auto_drop", o_drop_r, 0);

    // Pipe write during a full init is dropped and flagged.
    clear_log();
    i_init = 1'b1; tick(); i_init = 1'b0;
    tick();
    i_pipe_wen = 1'b1; i_pipe_waddr = 3'd3; i_pipe_wdata = 16'hBEEF;
    tick();
    i_pipe_wen = 1'b0;
    wait_done("drop", 20);
    check_full("drop", 0);
    chk("drop_busy_cnt", busy_cnt, 8);
    beef = 0;
    foreach (q_data[i]) if (q_data[i] == 16'hBEEF) beef++;
    chk("drop_not_fwd", beef, 0);
    chk("drop_flag", o_drop_r, 1);

    // Wrapping range clear on bank 0 only.
    clear_log();
    i_clr_vld = 1'b1; i_clr_base = 3'd6; i_clr_len = 4'd4; i_clr_bank_mask = 2'b01;
    #1;
    chk("clr_rdy_idle", o_clr_rdy, 1);
    tick();
    i_clr_vld = 1'b0;
    wait_done("wrap", 20);
    chk("wrap_rdy_low", rdylo_cnt, 4);
    chk("wrap_nwr", q_addr.size(), 4);
    ea = '{6, 7, 0, 1};
    if (q_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("wrap_addr%0d", i), q_addr[i], ea[i]);
        chk($sformatf("wrap_wen%0d", i), q_wen[i], 2'b01);
        chk($sformatf("wrap_data%0d", i), q_data[i], IV);
      end
    end
    check_done_lat("wrap");
    chk("drop_sticky", o_drop_r, 1);

    // Zero-length clear: no writes, done on the following cycle.
    clear_log();
    i_clr_vld = 1'b1; i_clr_base = 3'd3; i_clr_len = 4'd0; i_clr_bank_mask = 2'b11;
    tick();
    i_clr_vld = 1'b0;
    chk("len0_done", o_done_r, 1);
    tick();
    chk("len0_done_fall", o_done_r, 0);
    chk("len0_nwr", q_addr.size(), 0);

    // Pipe write interleaved into a range clear.
    clear_log();
    i_clr_vld = 1'b1; i_clr_base = 3'd2; i_clr_len = 4'd3; i_clr_bank_mask = 2'b11;
    tick();
    i_clr_vld = 1'b0;
    tick();
    i_pipe_wen = 1'b1; i_pipe_waddr = 3'd5; i_pipe_wdata = 16'h1234;
    tick();
    i_pipe_wen = 1'b0;
    wait_done("ilv", 20);
    chk("ilv_nwr", q_addr.size(), 4);
    ea = '{2, 5, 3, 4};
    ed = '{IV, 16'h1234, IV, IV};
    if (q_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("ilv_addr%0d", i), q_addr[i], ea[i]);
        chk($sformatf("ilv_wen%0d", i), q_wen[i], 2'b11);
        chk($sformatf("ilv_data%0d", i), q_data[i], ed[i]);
      end
    end
    check_done_lat("ilv");

    // Re-init aborts a range clear after two writes.
    clear_log();
    i_clr_vld = 1'b1; i_clr_base = 3'd5; i_clr_len = 4'd6; i_clr_bank_mask = 2'b10;
    tick();
    i_clr_vld = 1'b0;
    tick(); tick();
    i_init = 1'b1; tick(); i_init = 1'b0;
    wait_done("abort", 30);
    tick(); tick(); tick();
    chk("abort_done_once", done_cnt, 1);
    chk("abort_nwr", q_addr.size(), 10);
    if (q_addr.size() >= 2) begin
      chk("abort_a0", q_addr[0], 5);
      chk("abort_w0", q_wen[0], 2'b10);
      chk("abort_a1", q_addr[1], 6);
      chk("abort_w1", q_wen[1], 2'b10);
    end
    check_full("abort", 2);
    if (q_cyc.size() == 10) chk("abort_done_lat", done_cyc, q_cyc[9] + 1);

    // Asynchronous reset in the middle of a full init.
    clear_log();
    i_init = 1'b1; tick(); i_init = 1'b0;
    found = 0;
    k = 0;
    while (found == 0 && k < 20) begin
      tick();
      k++;
      if (o_wen_r != 2'b00 && o_waddr_r == 3'd4) found = 1;
    end
    chk("mid_reach4", found, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_wen", o_wen_r, 0);
    chk("arst_addr", o_waddr_r, 0);
    chk("arst_data", o_wdata_r, 0);
    chk("arst_done", o_done_r, 0);
    chk("arst_drop", o_drop_r, 0);
    chk("arst_busy", o_busy_r, 1);
    #1 rst = 1'b1;
    clear_log();
    wait_done("rerun", 20);
    check_full("rerun", 0);

    // Randomized ops against a model of the table contents.
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 8; a++) m[b][a] = IV;
    for (int it = 0; it < 40; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 4) begin
        int n;
        n = int'($urandom_range(1, 4));
        for (int j = 0; j < n; j++) begin
          logic [AW-1:0] a;
          logic [W-1:0]  d;
          a = AW'($urandom_range(0, 7));
          d = W'($urandom);
          i_pipe_wen = 1'b1; i_pipe_waddr = a; i_pipe_wdata = d;
          m[0][a] = d; m[1][a] = d;
          tick();
        end
        i_pipe_wen = 1'b0;
        tick();
      end else if (op < 9) begin
        int base;
        int len;
        int eff;
        int pipes;
        logic [1:0] mask;
        base = int'($urandom_range(0, 7));
        len  = int'($urandom_range(0, 10));
        mask = 2'($urandom_range(0, 3));
        eff  = (len > 8) ? 8 : len;
        i_clr_vld = 1'b1; i_clr_base = AW'(base); i_clr_len = 4'(len); i_clr_bank_mask = mask;
        tick();
        i_clr_vld = 1'b0;
        if (eff == 0) begin
          chk($sformatf("rnd%0d_len0_done", it), o_done_r, 1);
        end else begin
          k = 0;
          pipes = 0;
          while (k < eff) begin
            if (pipes < 4 && $urandom_range(0, 3) == 0) begin
              logic [AW-1:0] a;
              logic [W-1:0]  d;
              a = AW'($urandom_range(0, 7));
              d = W'($urandom);
              i_pipe_wen = 1'b1; i_pipe_waddr = a; i_pipe_wdata = d;
              m[0][a] = d; m[1][a] = d;
              pipes++;
            end else begin
              i_pipe_wen = 1'b0;
              for (int b = 0; b < 2; b++)
                if (mask[b]) m[b][(base + k) % 8] = IV;
              k++;
            end
            tick();
          end
          i_pipe_wen = 1'b0;
          tick();
          chk($sformatf("rnd%0d_rng_done", it), o_done_r, 1);
          chk($sformatf("rnd%0d_rng_rdy", it), o_clr_rdy, 1);
        end
      end else begin
        i_init = 1'b1; tick(); i_init = 1'b0;
        wait_done($sformatf("rnd%0d_init", it), 20);
        for (int b = 0; b < 2; b++)
          for (int a = 0; a < 8; a++) m[b][a] = IV;
      end
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 8; a++)
          chk($sformatf("rnd%0d_mem_b%0d_a%0d", it, b, a), sh[b][a], m[b][a]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
